// File: rtl/act_pkg.sv
// ---------------------------------------------------------------------------
// act_pkg
// Shared types and constants for the activation word packer.
//
//   ACT_W      width of one activation byte from the tanh stage
//   WORD_W     width of a packed word on the bus side
//   LANES      bytes per packed word (little-endian, lane 0 in [7:0])
//   act_word_t one FIFO entry: last flag + packed data
//              (+ per-lane valid mask when ACT_WORD_PACKER_BYTEMASK_EN)
//   lane_e     byte-lane fill state of the packer
//
// Optional feature macro: ACT_WORD_PACKER_BYTEMASK_EN
// ---------------------------------------------------------------------------
package act_pkg;

  localparam int unsigned ACT_W  = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = 4;

  typedef struct packed {
`ifdef ACT_WORD_PACKER_BYTEMASK_EN
    logic [LANES-1:0]  mask;
`endif
    logic              last;
    logic [WORD_W-1:0] data;
  } act_word_t;

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    FILL3 = 2'd3
  } lane_e;

  // Next lane in the fill rotation; FILL3 wraps to FILL0.
  function automatic lane_e lane_next(input lane_e lane);
    lane_e nxt;
    unique case (lane)
      FILL0:   nxt = FILL1;
      FILL1:   nxt = FILL2;
      FILL2:   nxt = FILL3;
      default: nxt = FILL0;
    endcase
    return nxt;
  endfunction

  // Lanes 0..lane hold real bytes when a word is pushed from this lane.
  function automatic logic [LANES-1:0] lane_mask(input lane_e lane);
    logic [LANES-1:0] m;
    unique case (lane)
      FILL0:   m = 4'b0001;
      FILL1:   m = 4'b0011;
      FILL2:   m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/act_sync_fifo.sv
// ---------------------------------------------------------------------------
// act_sync_fifo
// First-word-fall-through synchronous FIFO of act_word_t entries.
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset (clears pointers, count, storage)
//   push_i       write push_word_i (ignored when full)
//   push_word_i  entry to write
//   pop_i        consume the head entry (ignored when empty)
//   head_o       current head entry, valid while !empty_o
//   count_o      occupancy, 0..DEPTH
//   full_o       count_o == DEPTH
//   empty_o      count_o == 0
//
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
// ---------------------------------------------------------------------------
module act_sync_fifo
  import act_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNT_W = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  act_word_t        push_word_i,
  input  logic             pop_i,
  output act_word_t        head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  act_word_t        mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (do_push) begin
        mem_q[wptr_q] <= push_word_i;
      end
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/act_word_packer.sv
// ---------------------------------------------------------------------------
// act_word_packer
// Packs 8-bit activation bytes from the tanh stage into little-endian 32-bit
// words, zero-padding the final partial word of each vector, and buffers the
// words in a FWFT FIFO for the bus/DMA reader.
//
// Ports:
//   clk_i         system clock
//   rst_i         asynchronous active-high reset
//   act_valid_i   activation byte valid
//   act_data_i    activation byte (opaque)
//   act_last_i    byte ends the current vector
//   act_ready_o   byte can be accepted (FIFO not full; registered state only)
//   word_valid_o  FIFO head holds a word
//   word_data_o   FIFO head word, byte 0 in [7:0]
//   word_last_o   head word ends a vector
//   word_mask_o   per-lane real-byte mask (only with ACT_WORD_PACKER_BYTEMASK_EN)
//   word_ready_i  consumer takes the head word
//   fifo_count_o  FIFO occupancy
//
// Optional feature macro: ACT_WORD_PACKER_BYTEMASK_EN
// ---------------------------------------------------------------------------
module act_word_packer
  import act_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              act_valid_i,
  input  logic [ACT_W-1:0]  act_data_i,
  input  logic              act_last_i,
  output logic              act_ready_o,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_data_o,
  output logic              word_last_o,
`ifdef ACT_WORD_PACKER_BYTEMASK_EN
  output logic [LANES-1:0]  word_mask_o,
`endif
  input  logic              word_ready_i,
  output logic [CNT_W-1:0]  fifo_count_o
);

  lane_e             lane_q, lane_d;
  logic [1:0]        lane_idx;
  logic [WORD_W-1:0] part_q, part_d;
  logic              accept;
  logic              push_en;
  act_word_t         push_word;
  act_word_t         head_word;
  logic              fifo_full;
  logic              fifo_empty;

  assign lane_idx = lane_q;

  assign act_ready_o = !fifo_full;
  assign accept      = act_valid_i && act_ready_o;
  assign push_en     = accept && ((lane_q == FILL3) || act_last_i);

  always_comb begin
    lane_d = lane_q;
    part_d = part_q;
    if (accept) begin
      part_d[{lane_idx, 3'b000} +: ACT_W] = act_data_i;
      lane_d = push_en ? FILL0 : lane_next(lane_q);
    end
  end

  // The completing byte bypasses the partial register so the word is pushed
  // in the same cycle; lanes above it are forced to zero regardless of what
  // an earlier vector left in part_q.
  always_comb begin
    push_word      = '0;
    push_word.last = act_last_i;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (2'(i) < lane_idx) begin
        push_word.data[i*ACT_W +: ACT_W] = part_q[i*ACT_W +: ACT_W];
      end else if (2'(i) == lane_idx) begin
        push_word.data[i*ACT_W +: ACT_W] = act_data_i;
      end
    end
`ifdef ACT_WORD_PACKER_BYTEMASK_EN
    push_word.mask = lane_mask(lane_q);
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_q <= FILL0;
      part_q <= '0;
    end else begin
      lane_q <= lane_d;
      part_q <= part_d;
    end
  end

  act_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_en),
    .push_word_i (push_word),
    .pop_i       (word_ready_i),
    .head_o      (head_word),
    .count_o     (fifo_count_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign word_valid_o = !fifo_empty;
  assign word_data_o  = head_word.data;
  assign word_last_o  = head_word.last;
`ifdef ACT_WORD_PACKER_BYTEMASK_EN
  assign word_mask_o  = head_word.mask;
`endif

endmodule

// File: tb/tb_act_word_packer.sv
module tb_act_word_packer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          act_valid;
  logic [7:0]    act_data;
  logic          act_last;
  logic          act_ready;
  logic          word_valid;
  logic [31:0]   word_data;
  logic          word_last;
  logic          word_ready;
  logic [CW-1:0] fifo_count;
`ifdef ACT_WORD_PACKER_BYTEMASK_EN
  logic [3:0]    word_mask;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  act_word_packer #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .act_valid_i  (act_valid),
    .act_data_i   (act_data),
    .act_last_i   (act_last),
    .act_ready_o  (act_ready),
    .word_valid_o (word_valid),
    .word_data_o  (word_data),
    .word_last_o  (word_last),
`ifdef ACT_WORD_PACKER_BYTEMASK_EN
    .word_mask_o  (word_mask),
`endif
    .word_ready_i (word_ready),
    .fifo_count_o (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        rdy;
    logic        e_wv;
    logic [31:0] e_data;
    logic        e_last;
    logic [2:0]  e_cnt;
    logic [3:0]  e_mask;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic l, logic rdy, logic e_wv,
                              logic [31:0] e_data, logic e_last, logic [2:0] e_cnt,
                              logic [3:0] e_mask);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.rdy = rdy; r.e_wv = e_wv;
    r.e_data = e_data; r.e_last = e_last; r.e_cnt = e_cnt; r.e_mask = e_mask;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] b0);
    logic [7:0] b1, b2, b3;
    b1 = b0 + 8'd1;
    b2 = b0 + 8'd2;
    b3 = b0 + 8'd3;
    return {b3, b2, b1, b0};
  endfunction

  logic [32:0] sb[$];
  logic [31:0] acc;
  logic [7:0]  s;

  // Sends one full word (4 bytes); pops the head on the 4th byte when rdy_on_last.
  task automatic send_word(input bit rdy_on_last, input bit last_flag);
    for (int j = 0; j < 4; j++) begin
      act_valid  = 1'b1;
      act_data   = s;
      act_last   = (j == 3) && last_flag;
      word_ready = rdy_on_last && (j == 3);
      acc[8*j +: 8] = s;
      if (word_ready) begin
        chk("wrap_head_data", word_data, sb[0][31:0]);
        chk("wrap_head_last", 32'(word_last), 32'(sb[0][32]));
        void'(sb.pop_front());
      end
      tick();
      s = s + 8'd1;
    end
    sb.push_back({last_flag, acc});
    act_valid  = 1'b0;
    act_last   = 1'b0;
    word_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic acc_now;

    rst = 1'b1;
    act_valid = 1'b0; act_data = '0; act_last = 1'b0; word_ready = 1'b0;
    tick();
    tick();
    chk("rst_act_ready",  32'(act_ready),  32'd1);
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_word_data",  word_data,       32'd0);
    chk("rst_word_last",  32'(word_last),  32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
`ifdef ACT_WORD_PACKER_BYTEMASK_EN
    chk("rst_word_mask",  32'(word_mask),  32'd0);
`endif
    rst = 1'b0;

    // Four-byte vector, six-byte vector, single-byte vector; consumer always ready.
    tbl.push_back(mk(1, 8'h11, 0, 1, 0, 32'h0,        0, 0, 4'h0));
    tbl.push_back(mk(1, 8'h22, 0, 1, 0, 32'h0,        0, 0, 4'h0));
    tbl.push_back(mk(1, 8'h33, 0, 1, 0, 32'h0,        0, 0, 4'h0));
    tbl.push_back(mk(1, 8'h44, 1, 1, 1, 32'h44332211, 1, 1, 4'hF));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 32'h0,        0, 0, 4'h0));
    tbl.push_back(mk(1, 8'h01, 0, 1, 0, 32'h0,        0, 0, 4'h0));
    tbl.push_back(mk(1, 8'h02, 0, 1, 0, 32'h0,        0, 0, 4'h0));
    tbl.push_back(mk(1, 8'h03, 0, 1, 0, 32'h0,        0, 0, 4'h0));
    tbl.push_back(mk(1, 8'h04, 0, 1, 1, 32'h04030201, 0, 1, 4'hF));
    tbl.push_back(mk(1, 8'h05, 0, 1, 0, 32'h0,        0, 0, 4'h0));
    tbl.push_back(mk(1, 8'h06, 1, 1, 1, 32'h00000605, 1, 1, 4'h3));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 32'h0,        0, 0, 4'h0));
    tbl.push_back(mk(1, 8'hA5, 1, 1, 1, 32'h000000A5, 1, 1, 4'h1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 32'h0,        0, 0, 4'h0));

    foreach (tbl[i]) begin
      act_valid  = tbl[i].v;
      act_data   = tbl[i].d;
      act_last   = tbl[i].l;
      word_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_act_ready", i),  32'(act_ready),  32'd1);
      chk($sformatf("vec%0d_word_valid", i), 32'(word_valid), 32'(tbl[i].e_wv));
      chk($sformatf("vec%0d_fifo_count", i), 32'(fifo_count), 32'(tbl[i].e_cnt));
      if (tbl[i].e_wv) begin
        chk($sformatf("vec%0d_word_data", i), word_data,       tbl[i].e_data);
        chk($sformatf("vec%0d_word_last", i), 32'(word_last), 32'(tbl[i].e_last));
`ifdef ACT_WORD_PACKER_BYTEMASK_EN
        chk($sformatf("vec%0d_word_mask", i), 32'(word_mask), 32'(tbl[i].e_mask));
`endif
      end
    end
    act_valid = 1'b0; act_last = 1'b0; word_ready = 1'b0;

    // Backpressure: 20 byte attempts with the consumer stalled.
    n = 0;
    for (int c = 0; c < 20; c++) begin
      act_valid = 1'b1;
      act_data  = 8'hA0 + 8'(n);
      acc_now   = act_ready;
      tick();
      if (acc_now) n++;
      if (acc_now && n == 15) begin
        chk("bp_ready_at_15", 32'(act_ready),  32'd1);
        chk("bp_count_at_15", 32'(fifo_count), 32'd3);
      end
      if (acc_now && n == 16) begin
        chk("bp_ready_at_16", 32'(act_ready),  32'd0);
        chk("bp_count_at_16", 32'(fifo_count), 32'd4);
      end
      if (n == 16) chk("bp_head_stable", word_data, 32'hA3A2A1A0);
    end
    chk("bp_accepted_bytes", 32'(n), 32'd16);
    act_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_data", k), word_data,      pack4(8'hA0 + 8'(4*k)));
      chk($sformatf("drain%0d_last", k), 32'(word_last), 32'd0);
      word_ready = 1'b1;
      tick();
      chk($sformatf("drain%0d_count", k), 32'(fifo_count), 32'(3 - k));
      if (k == 0) chk("drain_ready_rise", 32'(act_ready), 32'd1);
    end
    word_ready = 1'b0;
    chk("drain_empty_valid", 32'(word_valid), 32'd0);

    // Simultaneous push/pop at count 2 across several pointer wraps.
    s = 8'h30;
    send_word(1'b0, 1'b0);
    send_word(1'b0, 1'b0);
    chk("wrap_preload_count", 32'(fifo_count), 32'd2);
    for (int w = 0; w < 12; w++) begin
      send_word(1'b1, w == 11);
      chk($sformatf("wrap%0d_count", w), 32'(fifo_count), 32'd2);
    end
    for (int k = 0; k < 2; k++) begin
      chk("wrap_tail_data", word_data,      sb[0][31:0]);
      chk("wrap_tail_last", 32'(word_last), 32'(sb[0][32]));
      void'(sb.pop_front());
      word_ready = 1'b1;
      tick();
    end
    word_ready = 1'b0;
    chk("wrap_final_count", 32'(fifo_count), 32'd0);

    // Reset mid-vector with a buffered word, then a clean vector.
    for (int j = 0; j < 6; j++) begin
      act_valid = 1'b1;
      act_data  = (j < 4) ? 8'h50 + 8'(j) : 8'h60 + 8'(j - 4);
      tick();
    end
    act_valid = 1'b0;
    chk("pre_rst_count", 32'(fifo_count), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_act_ready",  32'(act_ready),  32'd1);
    chk("async_rst_word_valid", 32'(word_valid), 32'd0);
    chk("async_rst_word_data",  word_data,       32'd0);
    chk("async_rst_word_last",  32'(word_last),  32'd0);
    chk("async_rst_fifo_count", 32'(fifo_count), 32'd0);
    tick();
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      act_valid = 1'b1;
      act_data  = (j == 0) ? 8'hDE : (j == 1) ? 8'hAD : (j == 2) ? 8'hBE : 8'hEF;
      act_last  = (j == 3);
      tick();
    end
    act_valid = 1'b0; act_last = 1'b0;
    chk("post_rst_valid", 32'(word_valid), 32'd1);
    chk("post_rst_data",  word_data,       32'hEFBEADDE);
    chk("post_rst_last",  32'(word_last),  32'd1);
    chk("post_rst_count", 32'(fifo_count), 32'd1);
`ifdef ACT_WORD_PACKER_BYTEMASK_EN
    chk("post_rst_mask",  32'(word_mask),  32'hF);
`endif
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("post_rst_drain", 32'(fifo_count), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
